display_scan_scheduler: RTL and testbench

- Owns the 4-digit 7-segment display and decides which source drives it for each game state.
- Sources: the menu scroller (28-bit packed text), the game field and the score.
- Latches one source snapshot per frame, so the display never tears mid-frame.
- Time-multiplexes the four digits and emits a frame pulse for the scrollers to advance on.

---
 rtl/display_scan_scheduler.sv | 154 +++++++++++++++
 tb/tb_display_scan_scheduler.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler: owns the 4-digit 7-segment display. Picks the
// source for the current game state, latches it once per frame so the
// picture never tears, scans the digits and blinks the field while paused.
module display_scan_scheduler #(
   parameter int SCAN_DIV       = 27000,
   parameter int BLINK_FRAMES   = 125,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  presente,
   input  logic [27:0] display_menu,
   input  logic [27:0] display_game,
   input  logic [27:0] display_score,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        frame_tick,
   output logic [1:0]  digit_idx
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
   localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_FRAMES - 1);
   localparam logic [6:0]       SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

   typedef enum logic [2:0] {
      SEL_BLANK = 3'd0,
      SEL_MENU  = 3'd1,
      SEL_GAME  = 3'd2,
      SEL_SCORE = 3'd3,
      SEL_BLINK = 3'd4
   } sel_e;

   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       digit_q, digit_d;
   sel_e             sel_q, sel_d;
   logic [27:0]      snap_q, snap_d;
   logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_on_q, blink_on_d;
   logic [6:0]       seg_q, seg_d;
   logic [3:0]       an_q, an_d;
   logic             ft_q, ft_d;
   logic             scan_tick, frame_bnd;
   logic [6:0]       raw_seg;

   assign scan_tick = (div_q == DIV_LAST);
   assign frame_bnd = scan_tick && (digit_q == 2'd3);

   // Digit-slot divider and digit pointer; the pointer moves once per slot.
   always_comb begin
      div_d   = scan_tick ? '0 : div_q + 1'b1;
      digit_d = scan_tick ? digit_q + 2'd1 : digit_q;
   end

   // Selector state register: only changes at a frame boundary.
   always_ff @(posedge clk) begin
      if (rst) sel_q <= SEL_BLANK;
      else     sel_q <= sel_d;
   end

   // Next selector: map the game state onto a display source at frame boundaries.
   always_comb begin
      sel_d = sel_q;
      if (frame_bnd) begin
         case (presente)
            3'd1, 3'd2: sel_d = SEL_MENU;
            3'd3:       sel_d = SEL_GAME;
            3'd4:       sel_d = SEL_SCORE;
            3'd5:       sel_d = SEL_BLINK;
            default:    sel_d = SEL_BLANK;
         endcase
      end
   end

   // Snapshot and blink phase for the frame about to start.
   always_comb begin
      snap_d      = snap_q;
      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;
      if (frame_bnd) begin
         case (sel_d)
            SEL_MENU:             snap_d = display_menu;
            SEL_GAME, SEL_BLINK:  snap_d = display_game;
            SEL_SCORE:            snap_d = display_score;
            default:              snap_d = '0;
         endcase
         if (sel_d == SEL_BLINK) begin
            if (sel_q != SEL_BLINK) begin
               // fresh pause always starts with the field visible
               blink_cnt_d = '0;
               blink_on_d  = 1'b1;
            end else if (blink_cnt_q == BLINK_LAST) begin
               blink_cnt_d = '0;
               blink_on_d  = ~blink_on_q;
            end else begin
               blink_cnt_d = blink_cnt_q + 1'b1;
            end
         end else begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
         end
      end
   end

   // Output decode: seg and an switch together, using the next digit and
   // the next snapshot so the first digit of a frame already shows new data.
   always_comb begin
      an_d    = an_q;
      seg_d   = seg_q;
      ft_d    = frame_bnd;
      raw_seg = 7'h00;
      if (scan_tick) begin
         an_d = ~(4'b0001 << digit_d);
         case (digit_d)
            2'd0:    raw_seg = snap_d[6:0];
            2'd1:    raw_seg = snap_d[13:7];
            2'd2:    raw_seg = snap_d[20:14];
            default: raw_seg = snap_d[27:21];
         endcase
         if ((sel_d == SEL_BLINK) && !blink_on_d) raw_seg = 7'h00;
         seg_d = SEG_ACTIVE_LOW ? ~raw_seg : raw_seg;
      end
   end

   // Datapath registers; reset blanks the display at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q       <= '0;
         digit_q     <= 2'd3;
         snap_q      <= '0;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
         seg_q       <= SEG_OFF;
         an_q        <= 4'b1111;
         ft_q        <= 1'b0;
      end else begin
         div_q       <= div_d;
         digit_q     <= digit_d;
         snap_q      <= snap_d;
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
         ft_q        <= ft_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_tick = ft_q;
   assign digit_idx  = digit_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Directed bench for display_scan_scheduler with SCAN_DIV=4, BLINK_FRAMES=2.
// A second instance with inverted segment polarity shares all inputs.
module tb_display_scan_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  presente;
   logic [27:0] display_menu, display_game, display_score;
   logic [6:0]  seg, seg_n;
   logic [3:0]  an, an_n;
   logic        frame_tick, frame_tick_n;
   logic [1:0]  digit_idx, digit_idx_n;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   always #5 clk = ~clk;

   display_scan_scheduler #(.SCAN_DIV(4), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst(rst), .presente(presente),
      .display_menu(display_menu), .display_game(display_game), .display_score(display_score),
      .seg(seg), .an(an), .frame_tick(frame_tick), .digit_idx(digit_idx)
   );

   display_scan_scheduler #(.SCAN_DIV(4), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1'b1)) dut_n (
      .clk(clk), .rst(rst), .presente(presente),
      .display_menu(display_menu), .display_game(display_game), .display_score(display_score),
      .seg(seg_n), .an(an_n), .frame_tick(frame_tick_n), .digit_idx(digit_idx_n)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, got, exp);
      end
   endtask

   // advance to the falling edge after the given number of rising edges since release
   task automatic goto(input int t);
      while (cyc < t) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg);
      chk({tag, ".an"},  {28'd0, an},  {28'd0, e_an});
      chk({tag, ".seg"}, {25'd0, seg}, {25'd0, e_seg});
   endtask

   initial begin
      rst           = 1'b1;
      presente      = 3'd1;
      display_menu  = 28'h0E3BFF7;
      display_game  = 28'h0;
      display_score = 28'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cyc = 0;

      // reset state
      chk_out("rst", 4'b1111, 7'h00);
      chk("rst.ft",  {31'd0, frame_tick}, 32'd0);
      chk("rst.dig", {30'd0, digit_idx}, 32'd3);
      chk("rst.segn", {25'd0, seg_n}, 32'h7F);

      // menu scan, first tick 4 cycles after release
      goto(3);  chk_out("pre", 4'b1111, 7'h00);
      goto(4);  chk_out("m0", 4'b1110, 7'h77);
      chk("m0.ft",  {31'd0, frame_tick}, 32'd1);
      chk("m0.dig", {30'd0, digit_idx}, 32'd0);
      chk("m0.segn", {25'd0, seg_n}, 32'h08);
      chk("m0.ann", {28'd0, an_n}, 32'hE);
      goto(5);  chk("m0.ft_off", {31'd0, frame_tick}, 32'd0);
      goto(8);  chk_out("m1", 4'b1101, 7'h7F);
      chk("m1.segn", {25'd0, seg_n}, 32'h00);
      goto(12); chk_out("m2", 4'b1011, 7'h0E);
      chk("m2.dig", {30'd0, digit_idx}, 32'd2);
      goto(16); chk_out("m3", 4'b0111, 7'h07);
      chk("m3.segn", {25'd0, seg_n}, 32'h78);

      // game frame, switch to score mid-frame
      presente      = 3'd3;
      display_game  = {7'h66, 7'h4F, 7'h5B, 7'h06};
      display_score = {7'h07, 7'h7D, 7'h6D, 7'h3F};
      goto(20); chk_out("g0", 4'b1110, 7'h06);
      chk("g0.ft", {31'd0, frame_tick}, 32'd1);
      goto(22); presente = 3'd4;
      goto(24); chk_out("g1", 4'b1101, 7'h5B);
      goto(28); chk_out("g2", 4'b1011, 7'h4F);
      goto(32); chk_out("g3", 4'b0111, 7'h66);
      goto(36); chk_out("s0", 4'b1110, 7'h3F);
      chk("s0.ft", {31'd0, frame_tick}, 32'd1);
      goto(40); chk_out("s1", 4'b1101, 7'h6D);

      // pause blink: 2 frames on, 2 frames off
      presente     = 3'd5;
      display_game = {4{7'h3F}};
      goto(52);  chk_out("bA", 4'b1110, 7'h3F);
      goto(68);  chk_out("bB", 4'b1110, 7'h3F);
      goto(84);  chk_out("bC", 4'b1110, 7'h00);
      goto(88);  chk_out("bC1", 4'b1101, 7'h00);
      goto(100); chk_out("bD", 4'b1110, 7'h00);
      goto(116); chk_out("bE", 4'b1110, 7'h3F);
      goto(132); chk_out("bF", 4'b1110, 7'h3F);
      goto(148); chk_out("bG", 4'b1110, 7'h00);
      presente = 3'd3;
      goto(152); chk_out("bG1", 4'b1101, 7'h00);
      goto(164); chk_out("unpause", 4'b1110, 7'h3F);

      // blank states keep scanning
      presente = 3'd0;
      goto(180); chk_out("off0", 4'b1110, 7'h00);
      chk("off0.ft", {31'd0, frame_tick}, 32'd1);
      goto(184); chk_out("off1", 4'b1101, 7'h00);
      goto(195); chk("off.ft_low", {31'd0, frame_tick}, 32'd0);
      goto(196); chk("off.ft_16", {31'd0, frame_tick}, 32'd1);
      presente = 3'd7;
      goto(212); chk_out("p7_0", 4'b1110, 7'h00);
      chk("p7.ft", {31'd0, frame_tick}, 32'd1);
      goto(220); chk_out("p7_2", 4'b1011, 7'h00);
      chk("p7.dig", {30'd0, digit_idx}, 32'd2);

      // reset while digit 2 is lit, then recover with the menu
      presente = 3'd1;
      rst = 1'b1;
      goto(221);
      chk_out("mrst", 4'b1111, 7'h00);
      chk("mrst.ft",  {31'd0, frame_tick}, 32'd0);
      chk("mrst.dig", {30'd0, digit_idx}, 32'd3);
      rst = 1'b0;
      goto(224); chk_out("rec.pre", 4'b1111, 7'h00);
      goto(225); chk_out("rec0", 4'b1110, 7'h77);
      chk("rec0.ft", {31'd0, frame_tick}, 32'd1);
      chk("rec0.segn", {25'd0, seg_n}, 32'h08);
      goto(229); chk_out("rec1", 4'b1101, 7'h7F);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
